// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the Safety BIST register bank: register byte offsets,
// field bit positions, the run-control state type and the STAT register layout.
// -----------------------------------------------------------------------------
package bist_pkg;

    // Register byte offsets (word aligned)
    localparam logic [7:0] BIST_CTRL_OFS = 8'h00;
    localparam logic [7:0] BIST_STAT_OFS = 8'h04;
    localparam logic [7:0] BIST_SEED_OFS = 8'h08;
    localparam logic [7:0] BIST_TOUT_OFS = 8'h0C;
    localparam logic [7:0] BIST_ERRC_OFS = 8'h10;
    localparam logic [7:0] BIST_SIG_OFS  = 8'h14;
    localparam logic [7:0] BIST_ID_OFS   = 8'h18;

    // CTRL fields
    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_ABORT_BIT  = 2;

    // STAT fields
    localparam int STAT_BUSY_BIT    = 0;
    localparam int STAT_DONE_BIT    = 1;
    localparam int STAT_FAIL_BIT    = 2;
    localparam int STAT_TIMEOUT_BIT = 3;

    localparam logic [15:0] ERRC_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN
    } bist_state_e;

    // Packed MSB-first so the struct maps directly onto STAT[3:0]
    typedef struct packed {
        logic timeout;
        logic fail;
        logic done;
        logic busy;
    } bist_stat_t;

    // Word-address match; the byte-lane bits of the address are ignored
    function automatic logic ofs_hit(input logic [7:0] addr, input logic [7:0] ofs);
        return (addr & 8'hFC) == ofs;
    endfunction

endpackage

// File: rtl/bist_watchdog.sv
// -----------------------------------------------------------------------------
// bist_watchdog
// Up-counting run watchdog. Counts while enabled and flags expiry in the cycle
// the count reaches limit-1. A limit of zero disables expiry.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset
//   i_clear  restart the count at 0 on the next edge
//   i_enable count this cycle (run in progress)
//   i_limit  watchdog limit in cycles
//   o_expire combinational expiry flag, only while enabled
// -----------------------------------------------------------------------------
module bist_watchdog #(
    parameter int TO_WIDTH = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,
    input  logic                i_enable,
    input  logic [TO_WIDTH-1:0] i_limit,
    output logic                o_expire
);

    logic [TO_WIDTH-1:0] r_count;
    logic [TO_WIDTH-1:0] w_last;

    assign w_last   = i_limit - 1'b1;
    assign o_expire = i_enable && (i_limit != '0) && (r_count == w_last);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/bist_reg_bank.sv
// -----------------------------------------------------------------------------
// bist_reg_bank
// Register bank and run-control sequencer for the Safety BIST IP. Decodes the
// simple register strobes from the APB front-end, launches the BIST engine,
// supervises the run with a watchdog and captures verdict, error count and
// signature. Raises a level interrupt when a completion status bit is set.
//
// State table
//   ST_IDLE | no run in progress; START launches a run
//   ST_RUN  | engine running; waits for done, watchdog expiry or ABORT
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reg_addr/reg_wdata        register byte offset / write data
//   reg_write_en/reg_read_en  write strobe / read qualifier
//   reg_rdata                 combinational read data (0 when not reading)
//   bist_start/bist_seed      start pulse and pattern seed to the engine
//   bist_done/bist_fail/
//   bist_signature            completion pulse, verdict and MISR signature
//   irq                       level interrupt
// -----------------------------------------------------------------------------
module bist_reg_bank
    import bist_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          TO_WIDTH   = 24,
    parameter logic [31:0] IP_ID      = 32'hB157_0001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            reg_addr,
    input  logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic                  reg_write_en,
    input  logic                  reg_read_en,
    output logic [DATA_WIDTH-1:0] reg_rdata,
    output logic                  bist_start,
    output logic [DATA_WIDTH-1:0] bist_seed,
    input  logic                  bist_done,
    input  logic                  bist_fail,
    input  logic [DATA_WIDTH-1:0] bist_signature,
    output logic                  irq
);

    bist_state_e           r_state;
    bist_stat_t            r_stat;
    logic                  r_irq_en;
    logic                  r_bist_start;
    logic [DATA_WIDTH-1:0] r_seed;
    logic [TO_WIDTH-1:0]   r_tout;
    logic [15:0]           r_errc;
    logic [DATA_WIDTH-1:0] r_sig;

    logic                  w_wr_ctrl;
    logic                  w_wr_stat;
    logic                  w_wr_seed;
    logic                  w_wr_tout;
    logic                  w_wr_errc;
    logic                  w_start_req;
    logic                  w_abort_req;
    logic                  w_fail_inc;
    logic                  w_expire;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_wr_ctrl = reg_write_en && ofs_hit(reg_addr, BIST_CTRL_OFS);
    assign w_wr_stat = reg_write_en && ofs_hit(reg_addr, BIST_STAT_OFS);
    assign w_wr_seed = reg_write_en && ofs_hit(reg_addr, BIST_SEED_OFS);
    assign w_wr_tout = reg_write_en && ofs_hit(reg_addr, BIST_TOUT_OFS);
    assign w_wr_errc = reg_write_en && ofs_hit(reg_addr, BIST_ERRC_OFS);

    assign w_start_req = w_wr_ctrl && reg_wdata[CTRL_START_BIT] && (r_state == ST_IDLE);
    assign w_abort_req = w_wr_ctrl && reg_wdata[CTRL_ABORT_BIT] && (r_state == ST_RUN);
    // Completions outside a run are dropped, so only count fails while running
    assign w_fail_inc  = bist_done && bist_fail && (r_state == ST_RUN);

    bist_watchdog #(
        .TO_WIDTH (TO_WIDTH)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_start_req),
        .i_enable (r_state == ST_RUN),
        .i_limit  (r_tout),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_stat       <= '0;
            r_irq_en     <= 1'b0;
            r_bist_start <= 1'b0;
            r_seed       <= '0;
            r_tout       <= '0;
            r_errc       <= '0;
            r_sig        <= '0;
        end else begin
            r_bist_start <= w_start_req;

            if (w_wr_ctrl) begin
                r_irq_en <= reg_wdata[CTRL_IRQ_EN_BIT];
            end
            if (w_wr_seed && (r_state == ST_IDLE)) begin
                r_seed <= reg_wdata;
            end
            if (w_wr_tout) begin
                r_tout <= reg_wdata[TO_WIDTH-1:0];
            end

            // W1C first; the hardware sets below are later NBAs and win
            if (w_wr_stat) begin
                r_stat.done    <= r_stat.done    & ~reg_wdata[STAT_DONE_BIT];
                r_stat.fail    <= r_stat.fail    & ~reg_wdata[STAT_FAIL_BIT];
                r_stat.timeout <= r_stat.timeout & ~reg_wdata[STAT_TIMEOUT_BIT];
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_start_req) begin
                        r_state        <= ST_RUN;
                        r_stat.busy    <= 1'b1;
                        r_stat.done    <= 1'b0;
                        r_stat.fail    <= 1'b0;
                        r_stat.timeout <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Engine completion beats a coincident watchdog expiry
                    if (bist_done) begin
                        r_sig       <= bist_signature;
                        r_stat.fail <= bist_fail;
                        r_stat.done <= 1'b1;
                        r_stat.busy <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else if (w_expire) begin
                        r_stat.timeout <= 1'b1;
                        r_stat.done    <= 1'b1;
                        r_stat.busy    <= 1'b0;
                        r_state        <= ST_IDLE;
                    end else if (w_abort_req) begin
                        r_stat.fail <= 1'b0;
                        r_stat.done <= 1'b1;
                        r_stat.busy <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_stat.busy <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase

            // A clear coinciding with a fail leaves exactly that one fail counted
            if (w_wr_errc) begin
                r_errc <= w_fail_inc ? 16'd1 : 16'd0;
            end else if (w_fail_inc && (r_errc != ERRC_MAX)) begin
                r_errc <= r_errc + 16'd1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (reg_read_en) begin
            case (reg_addr & 8'hFC)
                BIST_CTRL_OFS: w_rdata = DATA_WIDTH'({r_irq_en, 1'b0});
                BIST_STAT_OFS: w_rdata = DATA_WIDTH'(r_stat);
                BIST_SEED_OFS: w_rdata = r_seed;
                BIST_TOUT_OFS: w_rdata = DATA_WIDTH'(r_tout);
                BIST_ERRC_OFS: w_rdata = DATA_WIDTH'(r_errc);
                BIST_SIG_OFS:  w_rdata = r_sig;
                BIST_ID_OFS:   w_rdata = DATA_WIDTH'(IP_ID);
                default:       w_rdata = '0;
            endcase
        end
    end

    assign reg_rdata  = w_rdata;
    assign bist_start = r_bist_start;
    assign bist_seed  = r_seed;
    assign irq        = r_irq_en && (r_stat.done || r_stat.fail || r_stat.timeout);

endmodule

// File: tb/tb_bist_reg_bank.sv
module tb_bist_reg_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_write_en;
    logic        reg_read_en;
    logic [31:0] reg_rdata;
    logic        bist_start;
    logic [31:0] bist_seed;
    logic        bist_done;
    logic        bist_fail;
    logic [31:0] bist_signature;
    logic        irq;

    always #5 clk = ~clk;

    bist_reg_bank dut (
        .clk            (clk),
        .rst            (rst),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_write_en   (reg_write_en),
        .reg_read_en    (reg_read_en),
        .reg_rdata      (reg_rdata),
        .bist_start     (bist_start),
        .bist_seed      (bist_seed),
        .bist_done      (bist_done),
        .bist_fail      (bist_fail),
        .bist_signature (bist_signature),
        .irq            (irq)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int start_cycles = 0;

    // cycles during which bist_start was seen high
    always @(negedge clk) if (bist_start === 1'b1) start_cycles++;

    // behavioural model of the programmer-visible state
    logic        m_busy, m_done, m_fail, m_to, m_irq_en;
    logic [31:0] m_seed, m_sig;
    logic [23:0] m_tout;
    logic [15:0] m_errc;
    int          m_pulses = 0;

    task automatic mdl_reset();
        m_busy = 0; m_done = 0; m_fail = 0; m_to = 0; m_irq_en = 0;
        m_seed = 0; m_sig = 0; m_tout = 0; m_errc = 0;
    endtask

    task automatic mdl_write(input logic [7:0] a, input logic [31:0] d);
        case (a[7:2])
            6'd0: begin
                m_irq_en = d[1];
                if (d[0] && !m_busy) begin
                    m_busy = 1; m_done = 0; m_fail = 0; m_to = 0; m_pulses++;
                end else if (d[2] && m_busy) begin
                    m_busy = 0; m_done = 1; m_fail = 0;
                end
            end
            6'd1: begin
                if (d[1]) m_done = 0;
                if (d[2]) m_fail = 0;
                if (d[3]) m_to = 0;
            end
            6'd2: if (!m_busy) m_seed = d;
            6'd3: m_tout = d[23:0];
            6'd4: m_errc = 0;
            default: ;
        endcase
    endtask

    task automatic mdl_done(input logic f, input logic [31:0] s);
        if (m_busy) begin
            m_sig = s; m_fail = f; m_done = 1; m_busy = 0;
            if (f && m_errc != 16'hFFFF) m_errc = m_errc + 1;
        end
    endtask

    task automatic mdl_timeout();
        m_to = 1; m_done = 1; m_busy = 0;
    endtask

    function automatic logic [31:0] exp_reg(input logic [7:0] a);
        case (a[7:2])
            6'd0: return {30'd0, m_irq_en, 1'b0};
            6'd1: return {28'd0, m_to, m_fail, m_done, m_busy};
            6'd2: return m_seed;
            6'd3: return {8'd0, m_tout};
            6'd4: return {16'd0, m_errc};
            6'd5: return m_sig;
            6'd6: return 32'hB157_0001;
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic peek(input logic [7:0] a, output logic [31:0] d);
        reg_addr = a; reg_read_en = 1'b1;
        #1;
        d = reg_rdata;
        reg_read_en = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_addr = a; reg_wdata = d; reg_write_en = 1'b1;
        @(negedge clk);
        reg_write_en = 1'b0;
        mdl_write(a, d);
    endtask

    // engine completion pulse in the current cycle
    task automatic drive_done(input logic f, input logic [31:0] s);
        bist_done = 1'b1; bist_fail = f; bist_signature = s;
        @(negedge clk);
        bist_done = 1'b0; bist_fail = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            peek(8'(i * 4), d);
            chk($sformatf("%s/reg%02h", tag, i * 4), d, exp_reg(8'(i * 4)));
        end
        chk({tag, "/irq"}, {31'd0, irq}, {31'd0, m_irq_en & (m_done | m_fail | m_to)});
        chk({tag, "/seed_out"}, bist_seed, m_seed);
        chk({tag, "/start_cycles"}, start_cycles, m_pulses);
    endtask

    initial begin
        logic [31:0] d, s;
        int          lat, tout;
        logic        f;

        rst = 1'b1; reg_addr = 0; reg_wdata = 0; reg_write_en = 0; reg_read_en = 0;
        bist_done = 0; bist_fail = 0; bist_signature = 0;
        mdl_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        check_all("reset");
        peek(8'h40, d);
        chk("unmapped_0x40", d, 32'd0);
        peek(8'h1B, d);
        chk("id_byte_lane", d, 32'hB157_0001);
        reg_addr = 8'h18; reg_read_en = 1'b0; #1;
        chk("rd_en_low", reg_rdata, 32'd0);

        // basic pass run
        wr(8'h08, 32'hA5A5_0000);
        wr(8'h00, 32'h3);
        chk("start_hi", {31'd0, bist_start}, 32'd1);
        @(negedge clk);
        chk("start_lo", {31'd0, bist_start}, 32'd0);
        check_all("running");
        repeat (8) @(negedge clk);
        s = $urandom;
        drive_done(1'b0, s);
        mdl_done(1'b0, s);
        check_all("pass_done");
        wr(8'h04, 32'h2);
        check_all("w1c_done");

        // watchdog timeout at limit 20
        wr(8'h0C, 32'd20);
        wr(8'h00, 32'h3);
        repeat (19) @(negedge clk);
        peek(8'h04, d);
        chk("tout_cycle19_busy", d, 32'h1);
        @(negedge clk);
        mdl_timeout();
        check_all("timeout");
        drive_done(1'b1, $urandom);
        check_all("late_done_dropped");

        // done on the same cycle the watchdog would expire
        wr(8'h0C, 32'd5);
        wr(8'h00, 32'h3);
        repeat (4) @(negedge clk);
        s = $urandom;
        drive_done(1'b0, s);
        mdl_done(1'b0, s);
        check_all("done_vs_timeout");
        wr(8'h0C, 32'd0);

        // three failing runs
        for (int k = 0; k < 3; k++) begin
            wr(8'h00, 32'h3);
            repeat (3) @(negedge clk);
            drive_done(1'b1, 32'hDEAD_BEEF);
            mdl_done(1'b1, 32'hDEAD_BEEF);
        end
        check_all("three_fails");
        wr(8'h10, $urandom);
        check_all("errc_clear");

        // ERRC clear coinciding with a fail increment
        wr(8'h00, 32'h3);
        repeat (2) @(negedge clk);
        s = $urandom;
        reg_addr = 8'h10; reg_wdata = 32'h0; reg_write_en = 1'b1;
        drive_done(1'b1, s);
        reg_write_en = 1'b0;
        mdl_write(8'h10, 32'h0);
        mdl_done(1'b1, s);
        check_all("errc_clear_vs_inc");

        // W1C of STAT coinciding with the hardware set
        wr(8'h00, 32'h3);
        repeat (2) @(negedge clk);
        s = $urandom;
        reg_addr = 8'h04; reg_wdata = 32'hE; reg_write_en = 1'b1;
        drive_done(1'b0, s);
        reg_write_en = 1'b0;
        mdl_write(8'h04, 32'hE);
        mdl_done(1'b0, s);
        check_all("w1c_vs_set");

        // writes during a run, then abort
        wr(8'h00, 32'h3);
        wr(8'h08, $urandom);
        wr(8'h00, 32'h3);
        repeat (2) @(negedge clk);
        check_all("run_writes");
        wr(8'h00, 32'h6);
        check_all("abort");

        // reset in the middle of a run
        wr(8'h00, 32'h3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_reset();
        repeat (3) @(negedge clk);
        check_all("mid_run_reset");
        wr(8'h00, 32'h3);
        repeat (4) @(negedge clk);
        s = $urandom;
        drive_done(1'b0, s);
        mdl_done(1'b0, s);
        check_all("after_reset_run");

        // randomized runs against the model
        for (int k = 0; k < 10; k++) begin
            wr(8'h08, $urandom);
            tout = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(2, 20));
            wr(8'h0C, 32'(tout));
            lat = int'($urandom_range(0, 24));
            f = 1'($urandom_range(0, 1));
            s = $urandom;
            wr(8'h00, {30'd0, 1'($urandom_range(0, 1)), 1'b1});
            repeat (lat) @(negedge clk);
            drive_done(f, s);
            if (tout != 0 && tout - 1 < lat) mdl_timeout();
            mdl_done(f, s);
            check_all($sformatf("rand%0d", k));
            wr(8'h04, {28'd0, 4'($urandom_range(0, 15))});
            check_all($sformatf("rand%0d_w1c", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
